regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//   Shares the single register-file write port (RegWrite/RD/WriteData) among N_REQ
//   writeback requesters (e.g. ALU result, load result) using round-robin arbitration.
//   Keeps a 32-entry busy scoreboard of destination registers with writes in flight,
//   so decode can stall on RAW/WAW hazards. Sits between the pipeline writeback sources
//   and the register file; drives the register file's write port exclusively.
// PARAMETERS
//   N_REQ       2    number of writeback requesters (>=2)
//   XLEN        64   data width of write data
//   REG_ADDR_W  5    register index width (32 architectural registers, x0 hardwired 0)
// PORTS
//   clk          in   1              rising-edge clock
//   reset        in   1              asynchronous, active-high reset
//   req_valid    in   N_REQ          requester i has a write pending
//   req_rd       in   N_REQ*5        dest index, requester i at [i*5 +: 5]
//   req_data     in   N_REQ*XLEN     write data, requester i at [i*XLEN +: XLEN]
//   req_ready    out  N_REQ          one-hot grant; request i accepted when valid&ready
//   rf_we        out  1              to register file RegWrite (registered)
//   rf_rd        out  5              to register file RD (registered)
//   rf_wdata     out  XLEN           to register file WriteData (registered)
//   alloc_valid  in   1              decode issues an instruction writing alloc_rd
//   alloc_rd     in   5              destination being reserved
//   alloc_ready  out  1              reservation accepted this cycle
//   rs1, rs2     in   5 each         source indices to check
//   rs1_busy     out  1              rs1 has a write in flight
//   rs2_busy     out  1              rs2 has a write in flight
// BEHAVIOUR
//   Reset (async): rf_we=0, rf_rd=0, rf_wdata=0, busy[31:0]=0, rr_ptr=0; req_ready=0,
//     alloc_ready=0 while reset high. Accepted-but-uncommitted writes are discarded.
//   Arbitration (combinational): scan i = rr_ptr, rr_ptr+1, ... mod N_REQ; first valid
//     gets req_ready=1, all others 0. No valid -> req_ready all 0. At most one grant/cycle.
//   rr_ptr: on accept of requester g, rr_ptr <= (g+1) mod N_REQ; unchanged otherwise.
//   Requesters must hold rd/data stable while valid&!ready; never drop valid unaccepted.
//   Write port, latency 1: at the accept edge rf_rd<=rd, rf_wdata<=data,
//     rf_we<=(rd!=0). No accept -> rf_we<=0, rf_rd/rf_wdata hold. rd==0 request is still
//     granted and consumed (rr_ptr advances) but never asserts rf_we.
//   Throughput: one accepted write per cycle, back-to-back allowed.
//   Scoreboard: clear busy[rf_rd] at the edge where rf_we=1 (same edge the register file
//     writes). alloc accepted when alloc_valid & alloc_ready & alloc_rd!=0 -> busy[alloc_rd]<=1.
//   alloc_ready = (alloc_rd==0) | !busy[alloc_rd] | (rf_we & rf_rd==alloc_rd)  (WAW stall).
//   Same-edge set and clear of same index: set wins (busy stays 1).
//   alloc_rd==0: alloc_ready=1, no scoreboard change.
//   rsN_busy = busy[rsN] from registered state only; rsN==0 -> 0. A register cleared at
//     edge T reads not-busy from cycle T+1, when register-file read data is valid.
//   busy[0] is never set. Writes to a non-busy rd are legal (no scoreboard effect).
// TESTING
//   1 Reset mid-stream: req_valid=2'b11, assert reset async -> rf_we=0, busy=0,
//     req_ready=0 immediately; after release, grant goes to requester 0 (rr_ptr=0).
//   2 Round-robin: both valid 4 cycles (rd=5/data=A, rd=6/data=B) -> grants 0,1,0,1;
//     rf_we=1 each following cycle, rf_rd sequence 5,6,5,6.
//   3 Scoreboard: alloc rd=7 -> rs1=7 busy next cycle; requester 1 writes rd=7
//     data=0x1234 -> rf_we=1 one cycle later; rs1_busy=0 the cycle after that edge.
//   4 WAW: busy[9]=1, alloc rd=9 -> alloc_ready=0; same cycle rf_we=1,rf_rd=9 ->
//     alloc_ready=1, busy[9] stays 1 after edge.
//   5 x0: request rd=0 data=0xFFFF -> req_ready=1, rf_we stays 0; alloc rd=0 and
//     rs1=0 -> alloc_ready=1, rs1_busy=0, busy unchanged.
//   6 Hold: requester 1 valid while requester 0 granted -> req_ready[1]=0, rd/data held,
//     accepted next cycle with correct rf_rd/rf_wdata.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the writeback requesters, decode and the register-file
// write-port arbiter. The arbiter uses the slave modport; the producers of
// requests, reservations and source lookups use the master modport.
interface regfile_wb_arbiter_if #(
  parameter int N_REQ      = 2,
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
);
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*REG_ADDR_W-1:0] req_rd;
  logic [N_REQ*XLEN-1:0]       req_data;
  logic [N_REQ-1:0]            req_ready;

  logic                        rf_we;
  logic [REG_ADDR_W-1:0]       rf_rd;
  logic [XLEN-1:0]             rf_wdata;

  logic                        alloc_valid;
  logic [REG_ADDR_W-1:0]       alloc_rd;
  logic                        alloc_ready;

  logic [REG_ADDR_W-1:0]       rs1;
  logic [REG_ADDR_W-1:0]       rs2;
  logic                        rs1_busy;
  logic                        rs2_busy;

  modport master (
    output req_valid, req_rd, req_data, alloc_valid, alloc_rd, rs1, rs2,
    input  req_ready, rf_we, rf_rd, rf_wdata, alloc_ready, rs1_busy, rs2_busy
  );

  modport slave (
    input  req_valid, req_rd, req_data, alloc_valid, alloc_rd, rs1, rs2,
    output req_ready, rf_we, rf_rd, rf_wdata, alloc_ready, rs1_busy, rs2_busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port, plus a busy
// scoreboard of destination registers with writes in flight so decode can
// stall on RAW (rsN_busy) and WAW (alloc_ready) hazards.
module regfile_wb_arbiter #(
  parameter int N_REQ      = 2,
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  regfile_wb_arbiter_if.slave bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int NREG  = 1 << REG_ADDR_W;

  logic [PTR_W-1:0]      r_rr_ptr;
  logic                  r_rf_we;
  logic [REG_ADDR_W-1:0] r_rf_rd;
  logic [XLEN-1:0]       r_rf_wdata;
  logic [NREG-1:0]       r_busy;

  logic [N_REQ-1:0]      w_grant;
  logic                  w_gnt_any;
  logic [PTR_W-1:0]      w_gnt_idx;
  logic [REG_ADDR_W-1:0] w_sel_rd;
  logic [XLEN-1:0]       w_sel_data;
  logic                  w_alloc_ready;
  logic                  w_alloc_fire;

  // Requester index reached after stepping 'off' places past 'base', wrapping at N_REQ.
  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    return (s >= N_REQ) ? (s - N_REQ) : s;
  endfunction

  // Round-robin scan starting at r_rr_ptr; first valid requester wins the port.
  always_comb begin
    w_grant    = '0;
    w_gnt_any  = 1'b0;
    w_gnt_idx  = '0;
    w_sel_rd   = '0;
    w_sel_data = '0;
    if (!reset) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!w_gnt_any && bus.req_valid[wrap_idx(int'(r_rr_ptr), k)]) begin
          w_gnt_any  = 1'b1;
          w_gnt_idx  = PTR_W'(wrap_idx(int'(r_rr_ptr), k));
          w_grant[wrap_idx(int'(r_rr_ptr), k)] = 1'b1;
          w_sel_rd   = bus.req_rd[wrap_idx(int'(r_rr_ptr), k)*REG_ADDR_W +: REG_ADDR_W];
          w_sel_data = bus.req_data[wrap_idx(int'(r_rr_ptr), k)*XLEN +: XLEN];
        end
      end
    end
  end

  // Priority pointer moves just past the requester that was served.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_gnt_any) begin
      r_rr_ptr <= (w_gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : (w_gnt_idx + 1'b1);
    end
  end

  // Registered write port: one-cycle latency; x0 writes are consumed but never enable RegWrite.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rf_we    <= 1'b0;
      r_rf_rd    <= '0;
      r_rf_wdata <= '0;
    end else if (w_gnt_any) begin
      r_rf_we    <= (w_sel_rd != '0);
      r_rf_rd    <= w_sel_rd;
      r_rf_wdata <= w_sel_data;
    end else begin
      r_rf_we    <= 1'b0;
    end
  end

  // A reservation may proceed unless its register is busy and not being retired this cycle.
  always_comb begin
    w_alloc_ready = 1'b0;
    if (!reset) begin
      w_alloc_ready = (bus.alloc_rd == '0) || !r_busy[bus.alloc_rd] ||
                      (r_rf_we && (r_rf_rd == bus.alloc_rd));
    end
    w_alloc_fire = bus.alloc_valid && w_alloc_ready && (bus.alloc_rd != '0);
  end

  // Busy scoreboard: set on reservation, clear when the register file commits; set wins a tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy[0] <= 1'b0;
      for (int k = 1; k < NREG; k++) begin
        if (w_alloc_fire && (bus.alloc_rd == REG_ADDR_W'(k))) begin
          r_busy[k] <= 1'b1;
        end else if (r_rf_we && (r_rf_rd == REG_ADDR_W'(k))) begin
          r_busy[k] <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready   = w_grant;
  assign bus.rf_we       = r_rf_we;
  assign bus.rf_rd       = r_rf_rd;
  assign bus.rf_wdata    = r_rf_wdata;
  assign bus.alloc_ready = w_alloc_ready;
  assign bus.rs1_busy    = (bus.rs1 != '0) && r_busy[bus.rs1];
  assign bus.rs2_busy    = (bus.rs2 != '0) && r_busy[bus.rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios followed by random
// traffic, checked against a behavioural model and a queue of expected writes.
module tb_regfile_wb_arbiter;
  localparam int N  = 2;
  localparam int XW = 64;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.N_REQ(N), .XLEN(XW), .REG_ADDR_W(AW)) bus ();

  regfile_wb_arbiter #(.N_REQ(N), .XLEN(XW), .REG_ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [AW-1:0] rd;
    logic [XW-1:0] data;
  } wr_t;

  wr_t  q[$];
  wr_t  mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int   m_ptr;
  bit   m_busy[32];
  bit   m_we;
  int   m_rd;
  int   m_g;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_we  = 0;
    m_rd  = 0;
    m_g   = -1;
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
  endtask

  task automatic drive(input logic [1:0] v, input logic [4:0] rd0, input logic [63:0] d0,
                       input logic [4:0] rd1, input logic [63:0] d1,
                       input logic av, input logic [4:0] ard,
                       input logic [4:0] r1, input logic [4:0] r2);
    bus.req_valid   = v;
    bus.req_rd      = {rd1, rd0};
    bus.req_data    = {d1, d0};
    bus.alloc_valid = av;
    bus.alloc_rd    = ard;
    bus.rs1         = r1;
    bus.rs2         = r2;
  endtask

  // Called just after a falling edge with inputs driven: checks combinational
  // outputs against the model, advances the model, then waits for next falling edge.
  task automatic step();
    int            g;
    int            ard;
    bit            ar;
    logic [1:0]    eg;
    logic [AW-1:0] rd;
    #2;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && bus.req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("req_ready", 64'(bus.req_ready), 64'(eg));
    ard = int'(bus.alloc_rd);
    ar  = (ard == 0) || !m_busy[ard] || (m_we && m_rd == ard);
    chk("alloc_ready", 64'(bus.alloc_ready), 64'(ar));
    chk("rs1_busy", 64'(bus.rs1_busy), 64'(bus.rs1 != 0 && m_busy[bus.rs1]));
    chk("rs2_busy", 64'(bus.rs2_busy), 64'(bus.rs2 != 0 && m_busy[bus.rs2]));
    if (m_we) m_busy[m_rd] = 0;
    if (bus.alloc_valid && ar && ard != 0) m_busy[ard] = 1;
    m_g = g;
    if (g >= 0) begin
      rd = bus.req_rd[g*AW +: AW];
      if (rd != 0) q.push_back('{rd: rd, data: bus.req_data[g*XW +: XW]});
      m_we  = (rd != 0);
      m_rd  = int'(rd);
      m_ptr = (g + 1) % N;
    end else begin
      m_we = 0;
    end
    @(negedge clk);
  endtask

  // Write-port monitor: every commit seen on the port must match the oldest expected write.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        chk("rf_we_reset", 64'(bus.rf_we), 64'd0);
      end else if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("rf_we", 64'(bus.rf_we), 64'd1);
        chk("rf_rd", 64'(bus.rf_rd), 64'(mon_e.rd));
        chk("rf_wdata", bus.rf_wdata, mon_e.data);
      end else begin
        chk("rf_we_idle", 64'(bus.rf_we), 64'd0);
      end
    end
  end

  logic [1:0]  pv;
  logic [4:0]  prd[2];
  logic [63:0] pd[2];
  int          loser;

  initial begin
    reset = 1'b1;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rf_rd", 64'(bus.rf_rd), 64'd0);
    chk("reset_rf_wdata", bus.rf_wdata, 64'd0);
    chk("reset_alloc_ready", 64'(bus.alloc_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Round robin, both requesters continuously valid
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 5, 64'hAAAA_0000_0000_000A, 6, 64'hBBBB_0000_0000_000B, 0, 0, 0, 0);
      step();
    end

    // Reservation and retirement of x7
    drive(2'b00, 0, 0, 0, 0, 1, 7, 7, 0);           step();
    drive(2'b10, 0, 0, 7, 64'h1234, 0, 0, 7, 0);    step();
    drive(2'b00, 0, 0, 0, 0, 0, 0, 7, 0);           step();
    drive(2'b00, 0, 0, 0, 0, 0, 0, 7, 0);           step();
    drive(2'b00, 0, 0, 0, 0, 0, 0, 7, 0);           step();

    // WAW stall on x9, released by the committing write (set wins the tie)
    drive(2'b00, 0, 0, 0, 0, 1, 9, 9, 0);                     step();
    drive(2'b01, 9, 64'h9999, 0, 0, 1, 9, 9, 0);              step();
    drive(2'b00, 0, 0, 0, 0, 1, 9, 9, 0);                     step();
    drive(2'b00, 0, 0, 0, 0, 0, 0, 9, 9);                     step();
    drive(2'b00, 0, 0, 0, 0, 0, 0, 9, 9);                     step();

    // x0 request and x0 reservation
    drive(2'b01, 0, 64'hFFFF, 0, 0, 1, 0, 0, 0);    step();
    drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 9);           step();

    // Hold: losing requester keeps rd/data until served
    loser = (m_ptr == 0) ? 1 : 0;
    drive(2'b11, 3, 64'hD0D0, 4, 64'hD1D1, 0, 0, 0, 0); step();
    chk("hold_loser_not_granted", 64'(m_g != loser), 64'd1);
    drive(loser == 1 ? 2'b10 : 2'b01, 3, 64'hD0D0, 4, 64'hD1D1, 0, 0, 0, 0); step();
    drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0); step();

    // Random traffic obeying the hold rule
    pv = 2'b00;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pv[i]) begin
          pv[i]  = ($urandom_range(0, 9) < 6);
          prd[i] = 5'($urandom_range(0, 7));
          pd[i]  = {$urandom, $urandom};
        end
      end
      drive(pv, prd[0], pd[0], prd[1], pd[1], 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step();
      if (m_g >= 0) pv[m_g] = 1'b0;
    end
    drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0); step();

    // Reset asserted mid-stream with both requesters valid and x12 busy
    drive(2'b11, 12, 64'hC0, 13, 64'hC1, 1, 12, 12, 0); step();
    drive(2'b11, 12, 64'hC0, 13, 64'hC1, 0, 0, 12, 0);
    #1;
    chk("pre_reset_rs1_busy", 64'(bus.rs1_busy), 64'd1);
    chk("pre_reset_rf_we", 64'(bus.rf_we), 64'd1);
    #2;
    reset = 1'b1;
    q.delete();
    model_reset();
    #1;
    chk("async_reset_req_ready", 64'(bus.req_ready), 64'd0);
    chk("async_reset_rf_we", 64'(bus.rf_we), 64'd0);
    chk("async_reset_rs1_busy", 64'(bus.rs1_busy), 64'd0);
    chk("async_reset_alloc_ready", 64'(bus.alloc_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_reset_grant", 64'(bus.req_ready), 64'd1);
    #(-1 + 1);
    step();
    step();
    drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0); step();
    step();

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
